seg7_scan_driver: RTL

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with double-buffered display data.
// Optional decimal-point support: define SEG7_SCAN_DRIVER_DP_EN.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lzb,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
`ifdef SEG7_SCAN_DRIVER_DP_EN
  ,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    dp_out
`endif
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_TC   = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      frame_done_q, frame_done_d;
  logic [4*NUM_DIGITS-1:0]   sh_data_q, sh_data_d, disp_data_q, disp_data_d;
  logic [NUM_DIGITS-1:0]     sh_en_q, sh_en_d, disp_en_q, disp_en_d;
  logic                      sh_lzb_q, sh_lzb_d, disp_lzb_q, disp_lzb_d;
  logic                      pend_q, pend_d;
  logic [6:0]                seg_q, seg_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;

  logic                      slot_end, boundary, past_blank, show;
  logic [3:0]                nib_sel;
  logic [NUM_DIGITS-1:0]     quiet_mask, lz_blank;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h27;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  // A digit is "quiet" for leading-zero purposes when it is zero or disabled.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
      localparam logic [NUM_DIGITS-1:0] LOW_MASK =
        NUM_DIGITS'((64'd1 << (gi + 1)) - 64'd1);
      assign quiet_mask[gi] = (disp_data_q[4*gi +: 4] == 4'h0) || !disp_en_q[gi];
      if (gi == 0) begin : g_d0
        assign lz_blank[gi] = 1'b0;
      end else begin : g_dn
        assign lz_blank[gi] = disp_lzb_q && (disp_data_q[4*gi +: 4] == 4'h0) &&
                              (&(quiet_mask | LOW_MASK));
      end
    end

    if (BLANK_CYC == 0) begin : g_noblank
      assign past_blank = 1'b1;
    end else begin : g_blank
      assign past_blank = (cnt_q >= CW'(BLANK_CYC));
    end
  endgenerate

  assign slot_end = (cnt_q == CNT_TC);
  assign boundary = slot_end && (idx_q == IDX_LAST);
  assign nib_sel  = disp_data_q[{idx_q, 2'b00} +: 4];
  assign show     = past_blank && disp_en_q[idx_q] && !lz_blank[idx_q];

  always_comb begin
    cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
    idx_d       = idx_q;
    sh_data_d   = sh_data_q;
    sh_en_d     = sh_en_q;
    sh_lzb_d    = sh_lzb_q;
    disp_data_d = disp_data_q;
    disp_en_d   = disp_en_q;
    disp_lzb_d  = disp_lzb_q;
    pend_d      = pend_q;

    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    frame_done_d = (cnt_d == CNT_TC) && (idx_d == IDX_LAST);

    // A load landing on the boundary bypasses the shadow so it is never a frame late.
    if (load && boundary) begin
      disp_data_d = data_in;
      disp_en_d   = digit_en;
      disp_lzb_d  = lzb;
      pend_d      = 1'b0;
    end else begin
      if (boundary && pend_q) begin
        disp_data_d = sh_data_q;
        disp_en_d   = sh_en_q;
        disp_lzb_d  = sh_lzb_q;
        pend_d      = 1'b0;
      end
      if (load) begin
        sh_data_d = data_in;
        sh_en_d   = digit_en;
        sh_lzb_d  = lzb;
        pend_d    = 1'b1;
      end
    end

    seg_d = show ? decode(nib_sel) : 7'h7F;
    an_d  = show ? ~(NUM_DIGITS'(1) << idx_q) : '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      sh_data_q    <= '0;
      sh_en_q      <= '0;
      sh_lzb_q     <= 1'b0;
      disp_data_q  <= '0;
      disp_en_q    <= '0;
      disp_lzb_q   <= 1'b0;
      pend_q       <= 1'b0;
      seg_q        <= 7'h7F;
      an_q         <= '1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
      sh_data_q    <= sh_data_d;
      sh_en_q      <= sh_en_d;
      sh_lzb_q     <= sh_lzb_d;
      disp_data_q  <= disp_data_d;
      disp_en_q    <= disp_en_d;
      disp_lzb_q   <= disp_lzb_d;
      pend_q       <= pend_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_done = frame_done_q;

`ifdef SEG7_SCAN_DRIVER_DP_EN
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
  logic                  dp_q, dp_d;

  // Decimal points follow exactly the same shadow/boundary rules as the digits.
  always_comb begin
    sh_dp_d   = sh_dp_q;
    disp_dp_d = disp_dp_q;
    if (load && boundary) begin
      disp_dp_d = dp_in;
    end else begin
      if (boundary && pend_q) begin
        disp_dp_d = sh_dp_q;
      end
      if (load) begin
        sh_dp_d = dp_in;
      end
    end
    dp_d = show ? ~disp_dp_q[idx_q] : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_dp_q   <= '0;
      disp_dp_q <= '0;
      dp_q      <= 1'b1;
    end else begin
      sh_dp_q   <= sh_dp_d;
      disp_dp_q <= disp_dp_d;
      dp_q      <= dp_d;
    end
  end

  assign dp_out = dp_q;
`endif

endmodule
